// File: rtl/othello_flip_popcount.sv
// Othello move-execution helper.
// Flip unit: 3-stage free-running pipeline. It computes the mask of opponent
// discs flipped when the side to move plays square iPos.
// Popcount: a combinational population count. It is independent of the flip unit.
//
// Ports:
//   iCLOCK     in   1   rising-edge clock for the flip pipeline
//   iRESET_N   in   1   synchronous active-low reset; clears every flip stage
//   iPlayer    in   64  discs of side to move (bit i = row i/8, col i%8)
//   iOpponent  in   64  discs of opponent
//   iPos       in   7   square played, 0..63; 64..127 means no move
//   oFlip      out  64  registered flip mask, valid 3 cycles after capture
//   iCountX    in   64  popcount operand
//   oCount     out  7   number of set bits in iCountX (combinational)
module othello_flip_popcount (
    input  logic        iCLOCK,
    input  logic        iRESET_N,
    input  logic [63:0] iPlayer,
    input  logic [63:0] iOpponent,
    input  logic [6:0]  iPos,
    output logic [63:0] oFlip,
    input  logic [63:0] iCountX,
    output logic [6:0]  oCount
);

    localparam int unsigned BOARD_W = 64;
    localparam int unsigned CNT_W   = 7;
    localparam int unsigned NUM_DIR = 8;
    // A ray can hold at most 6 opponent discs between pos and a terminator.
    localparam int unsigned MAX_RUN = 6;

    localparam logic [BOARD_W-1:0] NOT_COL0 = 64'hFEFE_FEFE_FEFE_FEFE;
    localparam logic [BOARD_W-1:0] NOT_COL7 = 64'h7F7F_7F7F_7F7F_7F7F;

    // One step along a direction. Bits that wrapped across the board edge are masked off.
    function automatic logic [BOARD_W-1:0] step(input logic [BOARD_W-1:0] b,
                                                input logic [2:0]         dir);
        logic [BOARD_W-1:0] r;
        r = '0;
        case (dir)
            3'd0:    r = (b << 1) & NOT_COL0;   // E  (+1)
            3'd1:    r = (b >> 1) & NOT_COL7;   // W  (-1)
            3'd2:    r = b << 8;                // S  (+8)
            3'd3:    r = b >> 8;                // N  (-8)
            3'd4:    r = (b << 9) & NOT_COL0;   // SE (+9)
            3'd5:    r = (b >> 9) & NOT_COL7;   // NW (-9)
            3'd6:    r = (b << 7) & NOT_COL7;   // SW (+7)
            3'd7:    r = (b >> 7) & NOT_COL0;   // NE (-7)
            default: r = '0;
        endcase
        return r;
    endfunction

    // Grow the contiguous opponent run outward from pos. Keep it only if a player disc caps it.
    function automatic logic [BOARD_W-1:0] dir_flip(input logic [BOARD_W-1:0] player,
                                                    input logic [BOARD_W-1:0] opp,
                                                    input logic [BOARD_W-1:0] posbit,
                                                    input logic [2:0]         dir);
        logic [BOARD_W-1:0] run;
        run = step(posbit, dir) & opp;
        for (int unsigned k = 1; k < MAX_RUN; k++) begin
            run = run | (step(run, dir) & opp);
        end
        return ((step(run, dir) & player) != '0) ? run : '0;
    endfunction

    logic [BOARD_W-1:0]              pos_onehot_c;
    logic [BOARD_W-1:0]              s1_player;
    logic [BOARD_W-1:0]              s1_opp;
    logic [BOARD_W-1:0]              s1_posbit;
    logic [NUM_DIR-1:0][BOARD_W-1:0] dir_mask_c;
    logic [NUM_DIR-1:0][BOARD_W-1:0] s2_dir;
    logic [BOARD_W-1:0]              flip_or_c;
    logic [CNT_W-1:0]                count_c;

    // Position decode; the top bit of iPos selects "no move".
    always_comb begin
        pos_onehot_c = '0;
        if (!iPos[6]) begin
            pos_onehot_c = BOARD_W'(64'd1) << iPos[5:0];
        end
    end

    // Per-direction flip masks computed from the stage-1 registers.
    always_comb begin
        dir_mask_c = '0;
        for (int unsigned d = 0; d < NUM_DIR; d++) begin
            dir_mask_c[d] = dir_flip(s1_player, s1_opp, s1_posbit, 3'(d));
        end
    end

    // Merge the directions for the output stage.
    always_comb begin
        flip_or_c = '0;
        for (int unsigned d = 0; d < NUM_DIR; d++) begin
            flip_or_c = flip_or_c | s2_dir[d];
        end
    end

    // Pipeline registers; reset discards every in-flight board.
    always_ff @(posedge iCLOCK) begin
        if (!iRESET_N) begin
            s1_player <= '0;
            s1_opp    <= '0;
            s1_posbit <= '0;
            s2_dir    <= '0;
            oFlip     <= '0;
        end else begin
            s1_player <= iPlayer;
            s1_opp    <= iOpponent;
            s1_posbit <= pos_onehot_c;
            s2_dir    <= dir_mask_c;
            oFlip     <= flip_or_c;
        end
    end

    // Combinational population count; 7 bits hold 0..64.
    always_comb begin
        count_c = '0;
        for (int unsigned i = 0; i < BOARD_W; i++) begin
            count_c = count_c + CNT_W'(iCountX[i]);
        end
    end

    assign oCount = count_c;

endmodule

// File: tb/tb_othello_flip_popcount.sv
module tb_othello_flip_popcount;

    logic        iCLOCK;
    logic        iRESET_N;
    logic [63:0] iPlayer;
    logic [63:0] iOpponent;
    logic [6:0]  iPos;
    logic [63:0] oFlip;
    logic [63:0] iCountX;
    logic [6:0]  oCount;

    othello_flip_popcount dut (
        .iCLOCK    (iCLOCK),
        .iRESET_N  (iRESET_N),
        .iPlayer   (iPlayer),
        .iOpponent (iOpponent),
        .iPos      (iPos),
        .oFlip     (oFlip),
        .iCountX   (iCountX),
        .oCount    (oCount)
    );

    typedef struct {
        int          due;
        logic [63:0] val;
        int          tag;
    } exp_t;

    exp_t flip_q[$];
    exp_t cnt_q[$];
    exp_t e;

    int   cyc    = 0;
    int   tag_n  = 0;
    int   checks = 0;
    int   errors = 0;
    logic rst_q  = 1'b1;

    initial iCLOCK = 1'b0;
    always #5 iCLOCK = ~iCLOCK;

    always @(posedge iCLOCK) begin
        cyc   <= cyc + 1;
        rst_q <= iRESET_N;
    end

    // Monitor: compare the DUT against the scoreboard queues mid-cycle.
    always @(negedge iCLOCK) begin
        if (!rst_q) begin
            checks++;
            if (oFlip !== 64'd0) begin
                errors++;
                $display("FAIL reset_clear cyc=%0d oFlip=%h expected=0", cyc, oFlip);
            end
        end
        while (flip_q.size() > 0 && flip_q[0].due <= cyc) begin
            e = flip_q.pop_front();
            checks++;
            if (e.due != cyc || oFlip !== e.val) begin
                errors++;
                $display("FAIL flip[%0d] cyc=%0d due=%0d oFlip=%h expected=%h",
                         e.tag, cyc, e.due, oFlip, e.val);
            end
        end
        while (cnt_q.size() > 0 && cnt_q[0].due <= cyc) begin
            e = cnt_q.pop_front();
            checks++;
            if (e.due != cyc || 64'(oCount) !== e.val) begin
                errors++;
                $display("FAIL count[%0d] cyc=%0d oCount=%0d expected=%0d",
                         e.tag, cyc, oCount, e.val);
            end
        end
    end

    // Drive one cycle and push its expectations. Reset also kills the two boards still in flight.
    task automatic drive(input logic [63:0] p, input logic [63:0] o, input logic [6:0] pos,
                         input logic rst, input logic [63:0] exp_flip,
                         input logic [63:0] cx, input logic [6:0] exp_cnt);
        iPlayer   = p;
        iOpponent = o;
        iPos      = pos;
        iRESET_N  = rst;
        iCountX   = cx;
        if (!rst) begin
            foreach (flip_q[i]) begin
                if (flip_q[i].due == cyc + 1 || flip_q[i].due == cyc + 2) flip_q[i].val = 64'd0;
            end
        end
        flip_q.push_back('{due: cyc + 3, val: (rst ? exp_flip : 64'd0), tag: tag_n});
        cnt_q.push_back('{due: cyc, val: 64'(exp_cnt), tag: tag_n});
        tag_n++;
        @(posedge iCLOCK);
        #1;
    endtask

    task automatic idle();
        iPlayer   = 64'd0;
        iOpponent = 64'd0;
        iPos      = 7'd64;
        iRESET_N  = 1'b1;
        iCountX   = 64'd0;
        @(posedge iCLOCK);
        #1;
    endtask

    localparam logic [63:0] OPEN_P  = 64'h0000_0008_1000_0000;
    localparam logic [63:0] OPEN_O  = 64'h0000_0010_0800_0000;
    localparam logic [63:0] MULTI_P = 64'h0000_2800_2200_0000;
    localparam logic [63:0] MULTI_O = 64'h0000_0018_1408_0000;
    localparam logic [63:0] SPEC_O  = 64'h0000_0018_1800_0000;
    localparam logic [63:0] SPEC_P  = 64'h0000_0820_0028_0000;
    localparam logic [63:0] VERT_O  = 64'h0001_0101_0101_0100;

    logic [63:0] pb;

    initial begin
        iRESET_N  = 1'b0;
        iPlayer   = 64'd0;
        iOpponent = 64'd0;
        iPos      = 7'd64;
        iCountX   = 64'd0;
        @(posedge iCLOCK);
        #1;
        // Power-on reset cycles.
        drive(64'd0, 64'd0, 7'd64, 1'b0, 64'd0, 64'd0, 7'd0);
        drive(64'd0, 64'd0, 7'd64, 1'b0, 64'd0, 64'h8000_0000_0000_0001, 7'd2);
        // Back-to-back boards, one per cycle.
        drive(OPEN_P, OPEN_O, 7'd19, 1'b1, 64'h0000_0000_0800_0000, 64'hFFFF_FFFF_FFFF_FFFF, 7'd64);
        drive(OPEN_P, OPEN_O, 7'd64, 1'b1, 64'd0, 64'h0000_0000_0000_00FF, 7'd8);
        drive(OPEN_P, OPEN_O, 7'd127, 1'b1, 64'd0, 64'd0, 7'd0);
        drive(64'h100, 64'h80, 7'd6, 1'b1, 64'd0, 64'hAAAA_AAAA_AAAA_AAAA, 7'd32);
        drive(64'h8000, 64'h100, 7'd9, 1'b1, 64'd0, 64'h0000_0001_0000_0000, 7'd1);
        drive(SPEC_P, SPEC_O, 7'd20, 1'b1, 64'd0, 64'h8000_0000_0000_0000, 7'd1);
        drive(SPEC_P, SPEC_O, 7'd44, 1'b1, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 7'd63);
        drive(MULTI_P, MULTI_O, 7'd27, 1'b1, 64'h0000_0018_1400_0000, 64'h0F0F_0F0F_0F0F_0F0F, 7'd32);
        drive(64'h10, 64'h0E, 7'd0, 1'b1, 64'h0E, 64'h3, 7'd2);
        drive(64'h20, 64'h0E, 7'd0, 1'b1, 64'd0, 64'h0, 7'd0);
        drive(64'h80, 64'h7E, 7'd0, 1'b1, 64'h7E, 64'h1, 7'd1);
        drive(64'h100, 64'hFE, 7'd0, 1'b1, 64'd0, 64'hFF00_0000_0000_0000, 7'd8);
        drive(64'h0100_0000_0000_0000, VERT_O, 7'd0, 1'b1, VERT_O, 64'h0, 7'd0);
        drive(64'h1000_0000_0000_0000, 64'h6000_0000_0000_0000, 7'd63, 1'b1,
              64'h6000_0000_0000_0000, 64'h0, 7'd0);
        drive(64'h0000_0008_0000_0000, 64'h0002_0400_0000_0000, 7'd56, 1'b1,
              64'h0002_0400_0000_0000, 64'h0, 7'd0);
        // Popcount of posbit-1, including posbit 0.
        pb = 64'h10;
        drive(64'd0, 64'd0, 7'd64, 1'b1, 64'd0, pb - 64'd1, 7'd4);
        pb = 64'd0;
        drive(64'd0, 64'd0, 7'd64, 1'b1, 64'd0, pb - 64'd1, 7'd64);
        // Mid-stream reset: the three boards before and at the reset edge must vanish.
        drive(OPEN_P, OPEN_O, 7'd19, 1'b1, 64'h0000_0000_0800_0000, 64'h0, 7'd0);
        drive(64'h10, 64'h0E, 7'd0, 1'b1, 64'h0E, 64'h0, 7'd0);
        drive(64'h0100_0000_0000_0000, VERT_O, 7'd0, 1'b1, VERT_O, 64'h0, 7'd0);
        drive(64'h80, 64'h7E, 7'd0, 1'b0, 64'h7E, 64'hFFFF_0000_0000_0000, 7'd16);
        drive(MULTI_P, MULTI_O, 7'd27, 1'b1, 64'h0000_0018_1400_0000, 64'h0, 7'd0);
        drive(64'd0, 64'd0, 7'd64, 1'b1, 64'd0, 64'h0, 7'd0);
        // Drain the pipeline with a bounded wait.
        for (int k = 0; k < 8; k++) begin
            if (flip_q.size() > 0 || cnt_q.size() > 0) idle();
        end
        if (flip_q.size() > 0 || cnt_q.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected=0", flip_q.size() + cnt_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
